// File: rtl/fetch_buffer.sv
// Instruction-fetch buffer: issues one request per cycle and returns instructions to decode in order.
// Optional same-cycle bypass into decode when FETCH_BYPASS_EN is defined.
module fetch_buffer #(
   parameter int unsigned N     = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] pc_f,
   output logic         imem_req,
   output logic [N-1:0] imem_addr,
   input  logic         imem_ready,
   input  logic         imem_rvalid,
   input  logic [31:0]  imem_rdata,
   output logic [31:0]  instr_d,
   output logic [N-1:0] pc_d,
   output logic         valid_d,
   input  logic         StallD,
   input  logic         FlushD,
   output logic         StallF_buf
);

   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned CW  = PW + 1;
   localparam int unsigned CW1 = CW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [N-1:0]  r_q_pc    [DEPTH];
   logic [31:0]   r_q_instr [DEPTH];
   logic [N-1:0]  r_pend    [DEPTH];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [PW-1:0] r_pwr;
   logic [PW-1:0] r_prd;
   logic [CW-1:0] r_inflight;
   logic [CW-1:0] r_occ;
   logic [CW-1:0] r_drop;

   logic          w_credit;
   logic          w_accept;
   logic          w_rsp;
   logic          w_rsp_drop;
   logic          w_rsp_keep;
   logic          w_byp_show;
   logic          w_byp_take;
   logic          w_write;
   logic          w_q_valid;
   logic          w_pop;
   logic [CW-1:0] w_inflight_nxt;

   assign w_credit   = ({1'b0, r_inflight} + {1'b0, r_occ}) < CW1'(DEPTH);
   // Requests are gated by reset so nothing is issued while it is asserted.
   assign imem_req   = w_credit & ~FlushD & reset;
   assign imem_addr  = pc_f;
   assign w_accept   = imem_req & imem_ready;
   assign StallF_buf = ~w_accept;

   // A response with nothing outstanding is a protocol violation and is ignored.
   assign w_rsp      = imem_rvalid & (r_inflight != '0);
   assign w_rsp_drop = w_rsp & (r_drop != '0);
   assign w_rsp_keep = w_rsp & (r_drop == '0);

`ifdef FETCH_BYPASS_EN
   assign w_byp_show = w_rsp_keep & (r_occ == '0);
   assign w_byp_take = w_byp_show & ~StallD & ~FlushD;
`else
   assign w_byp_show = 1'b0;
   assign w_byp_take = 1'b0;
`endif

   assign w_write        = w_rsp_keep & ~w_byp_take;
   assign w_q_valid      = (r_occ != '0);
   assign w_pop          = w_q_valid & ~StallD & ~FlushD;
   assign w_inflight_nxt = r_inflight + CW'(w_accept) - CW'(w_rsp);

   always_comb begin
      valid_d = 1'b0;
      instr_d = NOP;
      pc_d    = '0;
      if (w_q_valid) begin
         valid_d = 1'b1;
         instr_d = r_q_instr[r_rd];
         pc_d    = r_q_pc[r_rd];
      end else if (w_byp_show) begin
         valid_d = 1'b1;
         instr_d = imem_rdata;
         pc_d    = r_pend[r_prd];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr       <= '0;
         r_rd       <= '0;
         r_pwr      <= '0;
         r_prd      <= '0;
         r_inflight <= '0;
         r_occ      <= '0;
         r_drop     <= '0;
      end else begin
         r_inflight <= w_inflight_nxt;
         if (FlushD) begin
            // Everything still outstanding after this cycle must be discarded on return.
            r_occ  <= '0;
            r_drop <= w_inflight_nxt;
            r_wr   <= '0;
            r_rd   <= '0;
         end else begin
            r_occ  <= r_occ + CW'(w_write) - CW'(w_pop);
            r_drop <= r_drop - CW'(w_rsp_drop);
            if (w_write) r_wr <= r_wr + PW'(1);
            if (w_pop)   r_rd <= r_rd + PW'(1);
         end
         if (w_accept) r_pwr <= r_pwr + PW'(1);
         if (w_rsp)    r_prd <= r_prd + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) r_pend[r_pwr] <= pc_f;
      if (w_write) begin
         r_q_pc[r_wr]    <= r_pend[r_prd];
         r_q_instr[r_wr] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer (DEPTH = 2, default build without bypass).
module tb_fetch_buffer;

   localparam int unsigned N = 32;
   localparam bit T = 1'b1;
   localparam bit F = 1'b0;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] I0  = 32'h0040_0093;
   localparam logic [31:0] I1  = 32'h0080_0113;
   localparam logic [31:0] I2  = 32'h00C0_0193;
   localparam logic [31:0] I3  = 32'h0100_0213;
   localparam logic [31:0] I4  = 32'h0140_0293;
   localparam logic [31:0] I5  = 32'h0180_0313;
   localparam logic [31:0] I6  = 32'h01C0_0393;
   localparam logic [31:0] I7  = 32'h0200_0413;
   localparam logic [31:0] I8  = 32'h0240_0493;
   localparam logic [31:0] IA  = 32'hAAAA_0013;
   localparam logic [31:0] IB  = 32'hBBBB_0013;
   localparam logic [31:0] IC  = 32'hCCCC_0013;
   localparam logic [31:0] BAD = 32'hDEAD_BEEF;

   typedef struct packed {
      logic        rdy;
      logic        rv;
      logic [31:0] data;
      logic [31:0] pc;
      logic        sd;
      logic        fd;
      logic        er;
      logic        es;
      logic        ev;
      logic [31:0] ep;
      logic [31:0] ei;
   } vec_t;

   logic         clk;
   logic         reset;
   logic [N-1:0] pc_f;
   logic         imem_req;
   logic [N-1:0] imem_addr;
   logic         imem_ready;
   logic         imem_rvalid;
   logic [31:0]  imem_rdata;
   logic [31:0]  instr_d;
   logic [N-1:0] pc_d;
   logic         valid_d;
   logic         StallD;
   logic         FlushD;
   logic         StallF_buf;

   int n_vec = 0;
   int n_err = 0;

   fetch_buffer #(.N(N), .DEPTH(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .pc_f       (pc_f),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .instr_d    (instr_d),
      .pc_d       (pc_d),
      .valid_d    (valid_d),
      .StallD     (StallD),
      .FlushD     (FlushD),
      .StallF_buf (StallF_buf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(bit rdy, bit rv, logic [31:0] data, logic [31:0] pc, bit sd,
                               bit fd, bit er, bit es, bit ev, logic [31:0] ep,
                               logic [31:0] ei);
      return '{rdy, rv, data, pc, sd, fd, er, es, ev, ep, ei};
   endfunction

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic drive(input logic rdy, input logic rv, input logic [31:0] data,
                        input logic [31:0] pc, input logic sd, input logic fd);
      @(negedge clk);
      imem_ready  = rdy;
      imem_rvalid = rv;
      imem_rdata  = data;
      pc_f        = pc;
      StallD      = sd;
      FlushD      = fd;
      #1;
   endtask

   task automatic test_reset();
      drive(F, F, 32'h0, 32'h0, F, F);
      n_vec++;
      if ({imem_req, StallF_buf, valid_d} !== 3'b010 || instr_d !== NOP || pc_d !== '0) begin
         n_err++;
         $display("FAIL reset_held: req/stall/valid=%b%b%b instr=%h pc=%h, want 010 %h 0",
                  imem_req, StallF_buf, valid_d, instr_d, pc_d, NOP);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_vec++;
      if (imem_req !== 1'b1 || valid_d !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: req=%b valid=%b, want req=1 valid=0", imem_req, valid_d);
      end
   endtask

   task automatic run_table(input string name, input vec_t v [$]);
      foreach (v[i]) begin
         drive(v[i].rdy, v[i].rv, v[i].data, v[i].pc, v[i].sd, v[i].fd);
         n_vec++;
         if ({imem_req, StallF_buf, valid_d} !== {v[i].er, v[i].es, v[i].ev} ||
             imem_addr !== v[i].pc) begin
            n_err++;
            $display("FAIL %s[%0d] req/stall/valid/addr: got %b%b%b %h, want %b%b%b %h", name, i,
                     imem_req, StallF_buf, valid_d, imem_addr, v[i].er, v[i].es, v[i].ev,
                     v[i].pc);
         end
         n_vec++;
         if (pc_d !== (v[i].ev ? v[i].ep : 32'h0) || instr_d !== (v[i].ev ? v[i].ei : NOP)) begin
            n_err++;
            $display("FAIL %s[%0d] pc_d/instr_d: got %h/%h, want %h/%h", name, i, pc_d, instr_d,
                     v[i].ev ? v[i].ep : 32'h0, v[i].ev ? v[i].ei : NOP);
         end
      end
   endtask

   task automatic test_stream();
      vec_t v [$];
      v.push_back(mk(T, F, 0,  32'h0, F, F, T, F, F, 32'h0, 0));
      v.push_back(mk(T, T, I0, 32'h4, F, F, T, F, F, 32'h0, 0));
      v.push_back(mk(T, T, I1, 32'h8, F, F, F, T, T, 32'h0, I0));
      v.push_back(mk(T, F, 0,  32'h8, F, F, T, F, T, 32'h4, I1));
      v.push_back(mk(F, T, I2, 32'hC, F, F, T, T, F, 32'h0, 0));
      v.push_back(mk(F, F, 0,  32'hC, F, F, T, T, T, 32'h8, I2));
      run_table("stream", v);
   endtask

   task automatic test_ready_low();
      vec_t v [$];
      for (int k = 0; k < 3; k++) v.push_back(mk(F, F, 0, 32'h20, F, F, T, T, F, 32'h0, 0));
      v.push_back(mk(T, F, 0,  32'h20, F, F, T, F, F, 32'h0,  0));
      v.push_back(mk(F, T, I3, 32'h20, F, F, T, T, F, 32'h0,  0));
      v.push_back(mk(F, F, 0,  32'h20, F, F, T, T, T, 32'h20, I3));
      v.push_back(mk(F, F, 0,  32'h20, F, F, T, T, F, 32'h0,  0));
      run_table("ready_low", v);
   endtask

   task automatic test_stall_full();
      vec_t v [$];
      v.push_back(mk(T, F, 0,  32'h40, T, F, T, F, F, 32'h0,  0));
      v.push_back(mk(T, T, I4, 32'h44, T, F, T, F, F, 32'h0,  0));
      v.push_back(mk(T, T, I5, 32'h48, T, F, F, T, T, 32'h40, I4));
      v.push_back(mk(T, F, 0,  32'h48, T, F, F, T, T, 32'h40, I4));
      v.push_back(mk(F, F, 0,  32'h48, F, F, F, T, T, 32'h40, I4));
      v.push_back(mk(F, F, 0,  32'h48, F, F, T, T, T, 32'h44, I5));
      v.push_back(mk(F, F, 0,  32'h48, F, F, T, T, F, 32'h0,  0));
      run_table("stall_full", v);
   endtask

   task automatic test_flush();
      vec_t v [$];
      v.push_back(mk(T, F, 0,   32'h60,  F, F, T, F, F, 32'h0,   0));
      v.push_back(mk(T, F, 0,   32'h64,  F, F, T, F, F, 32'h0,   0));
      v.push_back(mk(T, F, 0,   32'h100, F, T, F, T, F, 32'h0,   0));
      v.push_back(mk(T, T, BAD, 32'h100, F, F, F, T, F, 32'h0,   0));
      v.push_back(mk(T, T, BAD, 32'h100, F, F, T, F, F, 32'h0,   0));
      v.push_back(mk(F, T, I6,  32'h104, F, F, T, T, F, 32'h0,   0));
      v.push_back(mk(F, F, 0,   32'h104, F, F, T, T, T, 32'h100, I6));
      v.push_back(mk(F, F, 0,   32'h104, F, F, T, T, F, 32'h0,   0));
      run_table("flush", v);
   endtask

   task automatic test_flush_rvalid();
      vec_t v [$];
      v.push_back(mk(T, F, 0,  32'h80, F, F, T, F, F, 32'h0,  0));
      v.push_back(mk(T, T, IA, 32'h84, F, F, T, F, F, 32'h0,  0));
      v.push_back(mk(T, T, IB, 32'h88, F, T, F, T, T, 32'h80, IA));
      v.push_back(mk(F, F, 0,  32'h88, F, F, T, T, F, 32'h0,  0));
      v.push_back(mk(T, F, 0,  32'h90, F, F, T, F, F, 32'h0,  0));
      v.push_back(mk(F, T, IC, 32'h94, F, F, T, T, F, 32'h0,  0));
      v.push_back(mk(F, F, 0,  32'h94, F, F, T, T, T, 32'h90, IC));
      v.push_back(mk(F, F, 0,  32'h94, F, F, T, T, F, 32'h0,  0));
      run_table("flush_rvalid", v);
   endtask

   task automatic test_reset_mid();
      vec_t v [$];
      v.push_back(mk(T, F, 0,  32'hA0, T, F, T, F, F, 32'h0,  0));
      v.push_back(mk(T, T, I7, 32'hA4, T, F, T, F, F, 32'h0,  0));
      v.push_back(mk(F, T, I8, 32'hA8, T, F, F, T, T, 32'hA0, I7));
      v.push_back(mk(F, F, 0,  32'hA8, T, F, F, T, T, 32'hA0, I7));
      run_table("reset_mid", v);
      reset = 1'b0;
      #1;
      n_vec++;
      if ({imem_req, valid_d} !== 2'b00 || instr_d !== NOP || pc_d !== '0) begin
         n_err++;
         $display("FAIL reset_mid_assert: req/valid=%b%b instr=%h pc=%h, want 00 %h 0",
                  imem_req, valid_d, instr_d, pc_d, NOP);
      end
      drive(F, T, BAD, 32'hB0, F, F);
      reset = 1'b1;
      #1;
      n_vec++;
      if ({imem_req, valid_d} !== 2'b10) begin
         n_err++;
         $display("FAIL reset_mid_release: req/valid=%b%b, want 10", imem_req, valid_d);
      end
      drive(F, F, 32'h0, 32'hB0, F, F);
      n_vec++;
      if (valid_d !== 1'b0 || instr_d !== NOP) begin
         n_err++;
         $display("FAIL reset_mid_stray: valid=%b instr=%h, want 0 %h", valid_d, instr_d, NOP);
      end
      drive(T, F, 32'h0, 32'h200, F, F);
      n_vec++;
      if ({imem_req, StallF_buf} !== 2'b10) begin
         n_err++;
         $display("FAIL reset_mid_accept: req/stall=%b%b, want 10", imem_req, StallF_buf);
      end
   endtask

   initial begin
      reset       = 1'b0;
      pc_f        = '0;
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      StallD      = 1'b0;
      FlushD      = 1'b0;
      test_reset();
      test_stream();
      test_ready_low();
      test_stall_full();
      test_flush();
      test_flush_rvalid();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
